// File: rtl/priv_pipe_redirect.sv
// Pipeline redirect sequencer for trap entry and xRET.
// Issues a flush, waits for the pipe to drain, then holds a PC insert to fetch.
module priv_pipe_redirect #(
   parameter int MAX_DRAIN   = 16,
   parameter int DRAIN_CNT_W = 5
) (
   input  logic                  CLK,
   input  logic                  nRST,
   input  logic                  intr,
   input  logic                  ret,
   input  logic                  pipe_clear,
   input  logic                  cause_int,
   input  logic [4:0]            cause_code,
   input  logic [1:0]            cur_prv,
   input  logic [3:0][31:0]      xtvec,
   input  logic [3:0][31:0]      xepc_r,
   input  logic                  pipe_empty,
   input  logic                  pc_ack,
   output logic                  flush_req,
   output logic                  insert_pc,
   output logic [31:0]           priv_pc,
   output logic                  busy,
   output logic                  trap_taken,
   output logic                  ret_taken,
   output logic                  drain_timeout
);

   typedef enum logic [1:0] {
      IDLE,
      FLUSH,
      INSERT
   } state_t;

   state_t state, state_n;

   logic [31:0]            tvec;
   logic [31:0]            base;
   logic [31:0]            tgt_d;
   logic [31:0]            tgt_q;
   logic [DRAIN_CNT_W-1:0] cnt_q;
   logic                   accept;
   logic                   cnt_done;
   logic                   trap_q;
   logic                   ret_q;
   logic                   to_q;

   assign accept   = (state == IDLE) && pipe_clear && (intr || ret);
   assign cnt_done = (cnt_q == DRAIN_CNT_W'(MAX_DRAIN - 1));

   // Vectored mode only applies to interrupts; modes 10/11 act as direct.
   always_comb begin
      tvec  = xtvec[cur_prv];
      base  = {tvec[31:2], 2'b00};
      tgt_d = base;
      if (intr) begin
         if (tvec[1:0] == 2'b01 && cause_int)
            tgt_d = base + {25'd0, cause_code, 2'b00};
      end else begin
         tgt_d = {xepc_r[cur_prv][31:2], 2'b00};
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)
         state <= IDLE;
      else
         state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (accept) state_n = FLUSH;
         FLUSH:   if (pipe_empty || cnt_done) state_n = INSERT;
         INSERT:  if (pc_ack) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         tgt_q  <= '0;
         cnt_q  <= '0;
         trap_q <= 1'b0;
         ret_q  <= 1'b0;
         to_q   <= 1'b0;
      end else begin
         trap_q <= accept && intr;
         ret_q  <= accept && !intr;
         to_q   <= 1'b0;
         unique case (state)
            IDLE: begin
               if (accept) begin
                  tgt_q <= tgt_d;
                  cnt_q <= '0;
               end
            end
            FLUSH: begin
               // pipe_empty wins over the drain limit
               if (!pipe_empty) begin
                  cnt_q <= cnt_q + DRAIN_CNT_W'(1);
                  if (cnt_done) to_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      flush_req     = 1'b0;
      insert_pc     = 1'b0;
      priv_pc       = '0;
      busy          = 1'b0;
      trap_taken    = trap_q;
      ret_taken     = ret_q;
      drain_timeout = to_q;
      unique case (1'b1)
         (state == FLUSH): begin
            busy      = 1'b1;
            flush_req = 1'b1;
         end
         (state == INSERT): begin
            busy      = 1'b1;
            insert_pc = 1'b1;
            priv_pc   = tgt_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_priv_pipe_redirect.sv
// Directed bench for priv_pipe_redirect.
// A cycle-level behavioural model is checked every cycle alongside literal checks.
module tb_priv_pipe_redirect;

   localparam int MAX_DRAIN = 16;

   logic             CLK;
   logic             nRST;
   logic             intr;
   logic             ret;
   logic             pipe_clear;
   logic             cause_int;
   logic [4:0]       cause_code;
   logic [1:0]       cur_prv;
   logic [3:0][31:0] xtvec;
   logic [3:0][31:0] xepc_r;
   logic             pipe_empty;
   logic             pc_ack;
   logic             flush_req;
   logic             insert_pc;
   logic [31:0]      priv_pc;
   logic             busy;
   logic             trap_taken;
   logic             ret_taken;
   logic             drain_timeout;

   int n_vec;
   int n_miss;

   priv_pipe_redirect #(
      .MAX_DRAIN(MAX_DRAIN),
      .DRAIN_CNT_W(5)
   ) dut (
      .CLK(CLK),
      .nRST(nRST),
      .intr(intr),
      .ret(ret),
      .pipe_clear(pipe_clear),
      .cause_int(cause_int),
      .cause_code(cause_code),
      .cur_prv(cur_prv),
      .xtvec(xtvec),
      .xepc_r(xepc_r),
      .pipe_empty(pipe_empty),
      .pc_ack(pc_ack),
      .flush_req(flush_req),
      .insert_pc(insert_pc),
      .priv_pc(priv_pc),
      .busy(busy),
      .trap_taken(trap_taken),
      .ret_taken(ret_taken),
      .drain_timeout(drain_timeout)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] model_target(
      input logic is_trap, input logic [31:0] tv, input logic [31:0] ep,
      input logic ci, input logic [4:0] cc);
      longint unsigned b;
      longint unsigned s;
      if (!is_trap) return ep - (ep % 4);
      b = 64'(tv) - 64'(tv % 4);
      s = b;
      if ((tv % 4) == 1 && ci) s = b + 64'(cc) * 4;
      return 32'(s % 64'h1_0000_0000);
   endfunction

   // Model: a sequence is active or not; active means flushing or inserting.
   logic        m_active;
   logic        m_flushing;
   int          m_waited;
   logic [31:0] m_tgt;
   logic        m_trap;
   logic        m_ret;
   logic        m_to;

   always @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         m_active   <= 1'b0;
         m_flushing <= 1'b0;
         m_waited   <= 0;
         m_tgt      <= '0;
         m_trap     <= 1'b0;
         m_ret      <= 1'b0;
         m_to       <= 1'b0;
      end else begin
         m_trap <= 1'b0;
         m_ret  <= 1'b0;
         m_to   <= 1'b0;
         if (!m_active) begin
            if (pipe_clear && (intr || ret)) begin
               m_active   <= 1'b1;
               m_flushing <= 1'b1;
               m_waited   <= 0;
               m_tgt      <= model_target(intr, xtvec[cur_prv],
                                          xepc_r[cur_prv], cause_int,
                                          cause_code);
               m_trap     <= intr;
               m_ret      <= !intr;
            end
         end else if (m_flushing) begin
            m_waited <= m_waited + 1;
            if (pipe_empty) begin
               m_flushing <= 1'b0;
            end else if (m_waited + 1 >= MAX_DRAIN) begin
               m_flushing <= 1'b0;
               m_to       <= 1'b1;
            end
         end else if (pc_ack) begin
            m_active <= 1'b0;
         end
      end
   end

   always @(negedge CLK) begin
      chk("busy", busy, m_active);
      chk("flush_req", flush_req, m_active && m_flushing);
      chk("insert_pc", insert_pc, m_active && !m_flushing);
      chk("priv_pc", priv_pc, (m_active && !m_flushing) ? m_tgt : 32'd0);
      chk("trap_taken", trap_taken, m_trap);
      chk("ret_taken", ret_taken, m_ret);
      chk("drain_timeout", drain_timeout, m_to);
   end

   // Raises an event for one cycle and follows the sequence back to idle.
   task automatic run_event(
      input logic i, input logic r, input int ack_delay,
      input int empty_at, input bit poke,
      output logic [31:0] pc, output int nf, output int nins,
      output int nt, output int nr, output int nto, output int unstable);
      bit seen_busy;
      bit done;
      seen_busy = 0;
      done      = 0;
      pc        = '0;
      nf        = 0;
      nins      = 0;
      nt        = 0;
      nr        = 0;
      nto       = 0;
      unstable  = 0;
      pc_ack     = 1'b0;
      pipe_clear = 1'b1;
      intr       = i;
      ret        = r;
      for (int k = 0; k < 60; k++) begin
         @(negedge CLK);
         intr = 1'b0;
         ret  = 1'b0;
         if (busy) seen_busy = 1;
         nf  += int'(flush_req);
         nt  += int'(trap_taken);
         nr  += int'(ret_taken);
         nto += int'(drain_timeout);
         if (poke && flush_req && nf >= 2 && nf <= 4) intr = 1'b1;
         if (empty_at > 0 && flush_req && nf == empty_at) pipe_empty = 1'b1;
         if (insert_pc) begin
            if (nins == 0) pc = priv_pc;
            else if (priv_pc !== pc) unstable++;
            nins++;
            pc_ack = (nins > ack_delay);
         end else begin
            pc_ack = 1'b0;
         end
         if (seen_busy && !busy) begin
            done = 1;
            break;
         end
      end
      intr   = 1'b0;
      pc_ack = 1'b0;
      chk("seq_done", 32'(done), 32'd1);
   endtask

   logic [31:0] pc;
   int nf, nins, nt, nr, nto, unst;

   initial begin
      n_vec      = 0;
      n_miss     = 0;
      nRST       = 1'b0;
      intr       = 1'b0;
      ret        = 1'b0;
      pipe_clear = 1'b0;
      cause_int  = 1'b0;
      cause_code = 5'd0;
      cur_prv    = 2'd3;
      xtvec      = '0;
      xepc_r     = '0;
      pipe_empty = 1'b1;
      pc_ack     = 1'b0;
      repeat (2) @(negedge CLK);
      chk("rst_busy", busy, 0);
      chk("rst_priv_pc", priv_pc, 0);
      nRST = 1'b1;
      @(negedge CLK);

      // direct trap
      xtvec[3] = 32'h0000_0100;
      run_event(1, 0, 0, -1, 0, pc, nf, nins, nt, nr, nto, unst);
      chk("direct_pc", pc, 32'h0000_0100);
      chk("direct_nflush", nf, 1);
      chk("direct_nins", nins, 1);
      chk("direct_trap", nt, 1);
      chk("direct_ret", nr, 0);

      // vectored interrupt
      xtvec[3]   = 32'h8000_0001;
      cause_int  = 1'b1;
      cause_code = 5'd7;
      run_event(1, 0, 0, -1, 0, pc, nf, nins, nt, nr, nto, unst);
      chk("vect_pc", pc, 32'h8000_001C);
      cause_int = 1'b0;
      run_event(1, 0, 0, -1, 0, pc, nf, nins, nt, nr, nto, unst);
      chk("vect_exc_pc", pc, 32'h8000_0000);

      // mode 11 is direct; index by cur_prv
      cur_prv    = 2'd1;
      xtvec[1]   = 32'h0000_4003;
      cause_int  = 1'b1;
      cause_code = 5'd5;
      run_event(1, 0, 0, -1, 0, pc, nf, nins, nt, nr, nto, unst);
      chk("mode11_pc", pc, 32'h0000_4000);

      // vectored add wraps
      cur_prv    = 2'd0;
      xtvec[0]   = 32'hFFFF_FFF1;
      cause_code = 5'd31;
      run_event(1, 0, 0, -1, 0, pc, nf, nins, nt, nr, nto, unst);
      chk("wrap_pc", pc, 32'h0000_006C);
      cause_int = 1'b0;
      cur_prv   = 2'd3;

      // return
      xepc_r[3] = 32'h0000_2006;
      run_event(0, 1, 0, -1, 0, pc, nf, nins, nt, nr, nto, unst);
      chk("ret_pc", pc, 32'h0000_2004);
      chk("ret_pulse", nr, 1);
      chk("ret_notrap", nt, 0);

      // intr and ret together: trap wins
      run_event(1, 1, 0, -1, 0, pc, nf, nins, nt, nr, nto, unst);
      chk("both_pc", pc, 32'h8000_0000);
      chk("both_trap", nt, 1);
      chk("both_ret", nr, 0);

      // drain timeout, backpressure, intr during flush ignored
      pipe_empty = 1'b0;
      run_event(1, 0, 5, -1, 1, pc, nf, nins, nt, nr, nto, unst);
      chk("to_nflush", nf, MAX_DRAIN);
      chk("to_pulse", nto, 1);
      chk("to_nins", nins, 6);
      chk("to_stable", unst, 0);
      chk("to_trap_once", nt, 1);
      chk("to_pc", pc, 32'h8000_0000);

      // pipe_empty on the last flush cycle beats the timeout
      pipe_empty = 1'b0;
      run_event(1, 0, 0, MAX_DRAIN, 0, pc, nf, nins, nt, nr, nto, unst);
      chk("edge_nflush", nf, MAX_DRAIN);
      chk("edge_no_to", nto, 0);

      // early drain
      pipe_empty = 1'b0;
      run_event(0, 1, 0, 3, 0, pc, nf, nins, nt, nr, nto, unst);
      chk("early_nflush", nf, 3);
      chk("early_no_to", nto, 0);
      pipe_empty = 1'b1;

      // pipe_clear gating
      pipe_clear = 1'b0;
      intr       = 1'b1;
      repeat (4) begin
         @(negedge CLK);
         chk("gate_busy", busy, 0);
      end
      intr = 1'b0;
      @(negedge CLK);

      // async reset while inserting
      pipe_clear = 1'b1;
      pc_ack     = 1'b0;
      intr       = 1'b1;
      nf = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge CLK);
         intr = 1'b0;
         if (insert_pc) begin
            nf = 1;
            break;
         end
      end
      chk("rst_reach_insert", nf, 1);
      #2 nRST = 1'b0;
      #1;
      chk("arst_insert", insert_pc, 0);
      chk("arst_priv_pc", priv_pc, 0);
      chk("arst_busy", busy, 0);
      @(negedge CLK);
      nRST = 1'b1;
      repeat (5) begin
         @(negedge CLK);
         chk("post_rst_insert", insert_pc, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
